// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared definitions for the debounce scheduler: the FSM
//                state type and the default channel count / counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

    localparam int C_DEFAULT_N     = 4;
    localparam int C_DEFAULT_WIDTH = 4;

    // SCAN   : walk the round-robin pointer looking for a level mismatch
    // COUNT  : shared counter measures how long the owner stays mismatched
    // COMMIT : owner proved stable, waiting for a free event slot
    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/deb_sync.sv
`default_nettype none
// ============================================================================
//  Module      : deb_sync
//  Description : Single-bit two-flop synchronizer. Only instantiated by
//                debounce_scheduler when DEB_SYNC_EN is defined.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                d    - asynchronous input bit
//                q    - synchronized output (2 cycles latency)
//  Revision    : 1.0  initial release
// ============================================================================
module deb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule : deb_sync
`default_nettype wire

// File: rtl/debounce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_scheduler
//  Description : N-channel button debouncer sharing a single WIDTH-bit
//                stability counter. A round-robin pointer picks the next
//                mismatching channel; once it stays mismatched for
//                T = 2^WIDTH-1 counted cycles its clean level toggles and a
//                valid/ready event (channel, new level) is issued.
//  Config      : DEB_SYNC_EN - when defined, each raw input passes through a
//                two-flop synchronizer (deb_sync) before use.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                noisy_in   - raw bouncing inputs [N]
//                clean_out  - debounced levels [N]
//                evt_valid  - event pending
//                evt_ready  - consumer accepts event
//                evt_ch     - channel of pending event
//                evt_level  - new clean level of that channel
//                busy       - counter owned (COUNT or COMMIT)
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N     = C_DEFAULT_N,
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         noisy_in,
    output logic [N-1:0]         clean_out,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [$clog2(N)-1:0] evt_ch,
    output logic                 evt_level,
    output logic                 busy
);

    localparam int PW = $clog2(N);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N-1:0] w_s_in;

`ifdef DEB_SYNC_EN
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sync
            deb_sync u_deb_sync (
                .clk (clk),
                .rst (rst),
                .d   (noisy_in[gi]),
                .q   (w_s_in[gi])
            );
        end
    endgenerate
`else
    assign w_s_in = noisy_in;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [WIDTH-1:0] r_cnt;

    logic             w_scan_mis;
    logic             w_own_mis;
    logic             w_cnt_done;
    logic             w_slot_free;
    logic [PW-1:0]    w_ptr_inc;
    logic [PW-1:0]    w_owner_inc;

    assign w_scan_mis  = w_s_in[r_ptr]   != clean_out[r_ptr];
    assign w_own_mis   = w_s_in[r_owner] != clean_out[r_owner];
    assign w_cnt_done  = (r_cnt == {WIDTH{1'b1}});
    // A pending event that is being accepted this cycle frees the slot
    // for a commit in the same cycle.
    assign w_slot_free = !evt_valid || evt_ready;

    // Explicit wrap so non-power-of-two N never visits an invalid index.
    assign w_ptr_inc   = (r_ptr   == PW'(N - 1)) ? '0 : r_ptr   + PW'(1);
    assign w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);

    assign busy = (r_state != SCAN);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCAN: begin
                if (w_scan_mis) begin
                    w_state_next = COUNT;
                end
            end
            COUNT: begin
                if (!w_own_mis) begin
                    w_state_next = SCAN;
                end else if (w_cnt_done) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (w_slot_free) begin
                    w_state_next = SCAN;
                end
            end
            default: begin
                w_state_next = SCAN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointer, shared counter, clean levels, event slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            clean_out <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
        end else begin
            // Accepted event clears; a commit below may reload it.
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            case (r_state)
                SCAN: begin
                    if (w_scan_mis) begin
                        r_owner <= r_ptr;
                        r_cnt   <= '0;
                    end else begin
                        r_ptr <= w_ptr_inc;
                    end
                end
                COUNT: begin
                    if (!w_own_mis) begin
                        // Input bounced back: drop this debounce silently.
                        r_cnt <= '0;
                        r_ptr <= w_owner_inc;
                    end else if (!w_cnt_done) begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                COMMIT: begin
                    if (w_slot_free) begin
                        clean_out[r_owner] <= ~clean_out[r_owner];
                        evt_ch             <= r_owner;
                        evt_level          <= ~clean_out[r_owner];
                        evt_valid          <= 1'b1;
                        r_ptr              <= w_owner_inc;
                        r_cnt              <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : debounce_scheduler
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_scheduler
//  Description : Randomized + directed bench for debounce_scheduler with a
//                behavioural model and an event scoreboard.
//                Honours DEB_SYNC_EN (model adds the two-cycle input delay).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_scheduler;

    localparam int N     = 4;
    localparam int WIDTH = 4;
    localparam int CW    = $clog2(N);
    localparam int T     = (1 << WIDTH) - 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [N-1:0]  noisy_in  = '0;
    logic          evt_ready = 1'b0;
    logic [N-1:0]  clean_out;
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_level;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_scheduler #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .noisy_in  (noisy_in),
        .clean_out (clean_out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one channel at a time owns the stability
    // measurement; it must stay different from its clean level for T+1
    // owned cycles, then waits for a free event slot to flip.
    // ------------------------------------------------------------------
    typedef struct {
        int ch;
        bit lvl;
    } evt_t;

    evt_t         sb[$];
    bit [N-1:0]   m_clean  = '0;
    int           m_ptr    = 0;
    int           m_owner  = -1;   // -1: nobody owns the counter
    int           m_stable = 0;    // owned cycles seen with mismatch
    bit           m_proved = 1'b0; // owner passed the threshold
    bit           m_sv     = 1'b0;
    int           m_sch    = 0;
    bit           m_slvl   = 1'b0;
    bit [N-1:0]   m_sy1    = '0;
    bit [N-1:0]   m_sy2    = '0;

    task automatic model_step();
        bit [N-1:0] s;
        bit         slot_free;
        if (!rst) begin
            m_clean = '0; m_ptr = 0; m_owner = -1; m_stable = 0; m_proved = 0;
            m_sv = 0; m_sch = 0; m_slvl = 0; m_sy1 = '0; m_sy2 = '0;
            sb.delete();
            return;
        end
`ifdef DEB_SYNC_EN
        s     = m_sy2;
        m_sy2 = m_sy1;
        m_sy1 = noisy_in;
`else
        s = noisy_in;
`endif
        slot_free = !m_sv || evt_ready;
        if (m_sv && evt_ready) m_sv = 0;
        if (m_owner < 0) begin
            if (s[m_ptr] != m_clean[m_ptr]) begin
                m_owner  = m_ptr;
                m_stable = 0;
            end else begin
                m_ptr = (m_ptr + 1) % N;
            end
        end else if (!m_proved) begin
            if (s[m_owner] == m_clean[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_stable++;
                if (m_stable == T + 1) m_proved = 1;
            end
        end else if (slot_free) begin
            m_clean[m_owner] = ~m_clean[m_owner];
            m_sv   = 1;
            m_sch  = m_owner;
            m_slvl = m_clean[m_owner];
            sb.push_back('{ch: m_owner, lvl: m_clean[m_owner]});
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_proved = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares every cycle and pops events at each handshake.
    // ------------------------------------------------------------------
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            chk("clean_out", 32'(clean_out), 32'(m_clean));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("evt_valid", 32'(evt_valid), 32'(m_sv));
            if (m_sv) begin
                chk("evt_ch_hold", 32'(evt_ch), 32'(m_sch));
                chk("evt_level_hold", 32'(evt_level), 32'(m_slvl));
            end
            if (evt_valid && evt_ready && rst) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL evt_unexpected: got ch %0d level %0d expected no event", evt_ch, evt_level);
                end else begin
                    e = sb.pop_front();
                    chk("evt_ch", 32'(evt_ch), 32'(e.ch));
                    chk("evt_level", 32'(evt_level), 32'(e.lvl));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clean_out", 32'(clean_out), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #1;
        rst       = 1'b1;
        evt_ready = 1'b1;
        cycles(4);

        // single channel rises and holds
        noisy_in[1] = 1'b1;
        cycles(30);

        // bouncing channel never settles long enough
        for (int i = 0; i < 10; i++) begin
            noisy_in[2] = ~noisy_in[2];
            cycles(5);
        end
        cycles(30);

        // two channels rise together
        noisy_in[0] = 1'b1;
        noisy_in[3] = 1'b1;
        cycles(60);

        // consumer stalled while two channels change
        evt_ready   = 1'b0;
        noisy_in[0] = 1'b0;
        noisy_in[1] = 1'b0;
        cycles(60);
        evt_ready = 1'b1;
        cycles(20);

        // reset in the middle of a count
        noisy_in[2] = 1'b1;
        cycles(12);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("amid_clean_out", 32'(clean_out), 32'd0);
        chk("amid_evt_valid", 32'(evt_valid), 32'd0);
        chk("amid_evt_ch", 32'(evt_ch), 32'd0);
        chk("amid_evt_level", 32'(evt_level), 32'd0);
        chk("amid_busy", 32'(busy), 32'd0);
        cycles(2);
        rst = 1'b1;
        cycles(60);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 23) == 0) noisy_in[c] = ~noisy_in[c];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            cycles(1);
        end

        // drain
        evt_ready = 1'b1;
        cycles(200);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_debounce_scheduler
`default_nettype wire
